updown_counter: RTL and testbench

//   Parametrised synchronous modulo-N up/down counter; all bits share one clock (no ripple skew).

---
 rtl/updown_counter.sv | 112 +++++++++++
 tb/tb_updown_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Synchronous modulo-N up/down counter with clear, load, wrap/saturate and flags.
// Optional GRAY_OUT_EN adds a registered Gray-coded copy of q on port q_gray.
module updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter bit SATURATE  = 1'b0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef GRAY_OUT_EN
    output logic [WIDTH-1:0] q_gray,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   STEP = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] QMAX = MAXV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] QRST = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;
    logic             at_max;
    logic             at_zero;
    logic             ovf;
    logic             unf;
    logic             bad_load;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             lerr_nxt;

    assign q_ext    = {1'b0, q};
    assign inc      = q_ext + STEP;
    assign dec      = q_ext - STEP;
    assign at_max   = (q_ext == MAXV);
    assign at_zero  = (q == '0);
    // Overflow past the modulus and borrow out of zero, seen in the extra bit.
    assign ovf      = (inc > MAXV);
    assign unf      = dec[WIDTH];
    assign bad_load = ({1'b0, load_val} > MAXV);

    assign tc = en & (up ? at_max : at_zero);

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        lerr_nxt = 1'b0;
        if (clear) begin
            q_nxt = '0;
        end else if (load) begin
            if (bad_load) begin
                q_nxt    = QMAX;
                lerr_nxt = 1'b1;
            end else begin
                q_nxt = load_val;
            end
        end else if (en) begin
            if (up) begin
                if (!ovf) begin
                    q_nxt = inc[WIDTH-1:0];
                end else if (!SATURATE) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!unf) begin
                    q_nxt = dec[WIDTH-1:0];
                end else if (!SATURATE) begin
                    q_nxt    = QMAX;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= QRST;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_nxt;
            wrap     <= wrap_nxt;
            load_err <= lerr_nxt;
        end
    end

`ifdef GRAY_OUT_EN
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_gray <= to_gray(QRST);
        end else begin
            q_gray <= to_gray(q_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: a wrapping MODULUS=10 counter and a saturating MODULUS=16
// counter share random stimulus and are checked against an integer model.
module tb_updown_counter;

    localparam int W  = 4;
    localparam int MA = 10;
    localparam int RA = 3;
    localparam int MB = 16;
    localparam int RB = 5;

    typedef struct {
        logic [W-1:0] q;
        logic         tc;
        logic         wrap;
        logic         lerr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;

    logic [W-1:0] qa, qb;
    logic         tca, tcb, wa, wb, la, lb;
`ifdef GRAY_OUT_EN
    logic [W-1:0] ga, gb;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   ma, mb;
    exp_t qa_q[$];
    exp_t qb_q[$];

    always #5 clk = ~clk;

    updown_counter #(
        .WIDTH(W), .MODULUS(MA), .SATURATE(1'b0), .RESET_VAL(RA)
    ) dut_a (
`ifdef GRAY_OUT_EN
        .q_gray(ga),
`endif
        .clk(clk), .rst(rst), .en(en), .up(up),
        .clear(clear), .load(load), .load_val(load_val),
        .q(qa), .tc(tca), .wrap(wa), .load_err(la)
    );

    updown_counter #(
        .WIDTH(W), .MODULUS(MB), .SATURATE(1'b1), .RESET_VAL(RB)
    ) dut_b (
`ifdef GRAY_OUT_EN
        .q_gray(gb),
`endif
        .clk(clk), .rst(rst), .en(en), .up(up),
        .clear(clear), .load(load), .load_val(load_val),
        .q(qb), .tc(tcb), .wrap(wb), .load_err(lb)
    );

    // Reference: the count as a plain integer in 0..mod-1.
    function automatic exp_t step(input int mod, input bit sat, inout int m);
        exp_t e;
        int   n;
        e.wrap = 1'b0;
        e.lerr = 1'b0;
        if (clear) begin
            m = 0;
        end else if (load) begin
            if (int'(load_val) < mod) begin
                m = int'(load_val);
            end else begin
                m      = mod - 1;
                e.lerr = 1'b1;
            end
        end else if (en) begin
            n = up ? m + 1 : m - 1;
            if (n < 0 || n >= mod) begin
                if (!sat) begin
                    m      = (n + mod) % mod;
                    e.wrap = 1'b1;
                end
            end else begin
                m = n;
            end
        end
        e.q  = W'(m);
        e.tc = en && (up ? (m == mod - 1) : (m == 0));
        return e;
    endfunction

    function automatic exp_t rst_exp(input int mod, input int m);
        exp_t e;
        e.q    = W'(m);
        e.wrap = 1'b0;
        e.lerr = 1'b0;
        e.tc   = en && (up ? (m == mod - 1) : (m == 0));
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     nm, $time, act, req);
        end
    endtask

    task automatic cyc(input logic e, input logic u, input logic c,
                       input logic l, input logic [W-1:0] lv);
        @(negedge clk);
        rst      = 1'b0;
        en       = e;
        up       = u;
        clear    = c;
        load     = l;
        load_val = lv;
        qa_q.push_back(step(MA, 1'b0, ma));
        qb_q.push_back(step(MB, 1'b1, mb));
    endtask

    // Reset lands mid-cycle; it is then held across one rising edge.
    task automatic mid_reset();
        @(negedge clk);
        en       = 1'b1;
        up       = 1'($urandom_range(0, 1));
        clear    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        #2;
        ma = RA;
        mb = RB;
        repeat (2) begin
            qa_q.push_back(rst_exp(MA, ma));
            qb_q.push_back(rst_exp(MB, mb));
        end
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (qa_q.size() > 0) begin
                e = qa_q.pop_front();
                cmp("a_q", qa, e.q);
                cmp("a_tc", W'(tca), W'(e.tc));
                cmp("a_wrap", W'(wa), W'(e.wrap));
                cmp("a_load_err", W'(la), W'(e.lerr));
`ifdef GRAY_OUT_EN
                cmp("a_q_gray", ga, e.q ^ (e.q >> 1));
`endif
            end
            if (qb_q.size() > 0) begin
                e = qb_q.pop_front();
                cmp("b_q", qb, e.q);
                cmp("b_tc", W'(tcb), W'(e.tc));
                cmp("b_wrap", W'(wb), W'(e.wrap));
                cmp("b_load_err", W'(lb), W'(e.lerr));
`ifdef GRAY_OUT_EN
                cmp("b_q_gray", gb, e.q ^ (e.q >> 1));
`endif
            end
        end
    end

    initial begin : stim
        rst      = 1'b0;
        en       = 1'b0;
        up       = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        ma       = RA;
        mb       = RB;
        #1;
        repeat (2) begin
            qa_q.push_back(rst_exp(MA, ma));
            qb_q.push_back(rst_exp(MB, mb));
        end
        rst = 1'b1;

        repeat (14) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        repeat (9) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        mid_reset();
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                mid_reset();
            end else begin
                cyc(1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 9) == 0),
                    W'($urandom_range(0, 15)));
            end
        end

        @(posedge clk);
        #3;
        cmp("a_queue_left", W'(qa_q.size()), '0);
        cmp("b_queue_left", W'(qb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
